shift_sequencer: RTL and testbench

Multi-cycle controller that drives a 1-bit-per-step bidirectional shift datapath so it can shift an operand by an arbitrary amount.
- Accepts a job (operand, direction, mode, amount) through a valid/ready handshake.
- Applies one single-bit shift per clock, then returns the result with a one-cycle done pulse.
- Sits between a requesting datapath/FSM and the shifter slice; the shifter operates combinationally on the internal accumulator.

---
 rtl/shift_sequencer_if.sv | 24 ++
 rtl/shift_sequencer.sv | 79 +++++++
 tb/tb_shift_sequencer.sv | 114 +++++++++++
 3 files changed

// File: rtl/shift_sequencer_if.sv
// shift_sequencer_if: job request/result bundle between a requester and the shift sequencer.
interface shift_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] num;
    logic             d;
    logic [1:0]       mode;
    logic [AMT_W-1:0] amt;
    logic             abort;
    logic [WIDTH-1:0] y;
    logic             done;
    logic             busy;
    modport master (
        output start_valid, num, d, mode, amt, abort,
        input  start_ready, y, done, busy
    );
    modport slave (
        input  start_valid, num, d, mode, amt, abort,
        output start_ready, y, done, busy
    );
endinterface

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle shifter applying one single-bit shift per clock to an accumulator.
module shift_sequencer #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input logic             clk,
    input logic             rst_n,
    shift_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] y_r;
    logic [AMT_W-1:0] cnt;
    logic [1:0]       md;
    logic             dir;
    logic             done_r;
    logic             busy_r;
    // mode 11 falls through to logical; left shift ignores arithmetic
    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] a, input logic left, input logic [1:0] m);
        logic rot;
        logic fill_r;
        rot    = m == 2'b10;
        fill_r = rot ? a[0] : (m == 2'b01 ? a[WIDTH-1] : 1'b0);
        return left ? {a[WIDTH-2:0], rot ? a[WIDTH-1] : 1'b0} : {fill_r, a[WIDTH-1:1]};
    endfunction
    assign nxt             = step(acc, dir, md);
    assign bus.start_ready = state == IDLE;
    assign bus.y           = y_r;
    assign bus.done        = done_r;
    assign bus.busy        = busy_r;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            acc    <= '0;
            cnt    <= '0;
            md     <= '0;
            dir    <= 1'b0;
            y_r    <= '0;
            done_r <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start_valid) begin
                    acc    <= bus.num;
                    dir    <= bus.d;
                    md     <= bus.mode;
                    cnt    <= bus.amt;
                    busy_r <= 1'b1;
                    if (bus.amt == '0) begin
                        state  <= DONE;
                        y_r    <= bus.num;
                        done_r <= 1'b1;
                    end else begin
                        state <= SHIFT;
                    end
                end
                SHIFT: if (bus.abort) begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end else begin
                    acc <= nxt;
                    cnt <= cnt - 1'b1;
                    if (cnt == AMT_W'(1)) begin
                        state  <= DONE;
                        y_r    <= nxt;
                        done_r <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: directed jobs with hand-computed results, latency and handshake checks.
module tb_shift_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   lat;
    int   dn;
    shift_sequencer_if #(.WIDTH(8), .AMT_W(4)) bus ();
    shift_sequencer #(.WIDTH(8), .AMT_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    // one job; inputs are scrambled right after accept to prove they are not resampled
    task automatic run(input string tag, input logic [7:0] n, input logic dd, input logic [1:0] m,
                       input logic [3:0] a, input logic [7:0] exp_y);
        @(negedge clk);
        bus.num = n; bus.d = dd; bus.mode = m; bus.amt = a; bus.start_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start_valid = 1'b0;
        bus.num = ~n; bus.d = ~dd; bus.mode = ~m; bus.amt = a + 4'd3;
        lat = 1;
        if (a != 0) chk({tag, "_busy_shift"}, {31'd0, bus.busy}, 32'd1);
        while (!bus.done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, lat, a + 1);
        chk({tag, "_y"}, {24'd0, bus.y}, {24'd0, exp_y});
        chk({tag, "_busy_done"}, {31'd0, bus.busy}, 32'd1);
        @(negedge clk);
        chk({tag, "_idle"}, {29'd0, bus.done, bus.busy, bus.start_ready}, 32'b001);
    endtask
    initial begin
        bus.start_valid = 1'b0; bus.num = '0; bus.d = 1'b0; bus.mode = '0; bus.amt = '0; bus.abort = 1'b0;
        #12;
        chk("reset", {21'd0, bus.y, bus.done, bus.busy, bus.start_ready}, 32'b001);
        @(negedge clk);
        rst_n = 1'b1;
        run("rsh1", 8'd10, 1'b0, 2'b00, 4'd1, 8'd5);
        run("lsh1", 8'd5, 1'b1, 2'b00, 4'd1, 8'd10);
        run("lsh9", 8'hFF, 1'b1, 2'b00, 4'd9, 8'h00);
        run("asr3", 8'h96, 1'b0, 2'b01, 4'd3, 8'hF2);
        run("lsr3", 8'h96, 1'b0, 2'b00, 4'd3, 8'h12);
        run("rol1", 8'h81, 1'b1, 2'b10, 4'd1, 8'h03);
        run("rol8", 8'h81, 1'b1, 2'b10, 4'd8, 8'h81);
        run("ror1", 8'h81, 1'b0, 2'b10, 4'd1, 8'hC0);
        run("rol9", 8'h81, 1'b1, 2'b10, 4'd9, 8'h03);
        run("asr15", 8'h80, 1'b0, 2'b01, 4'd15, 8'hFF);
        run("asl2", 8'hC1, 1'b1, 2'b01, 4'd2, 8'h04);
        run("m11", 8'h80, 1'b0, 2'b11, 4'd1, 8'h40);
        run("amt0", 8'h3C, 1'b0, 2'b00, 4'd0, 8'h3C);
        // accept beats abort in IDLE
        bus.abort = 1'b1;
        run("abidle", 8'h5A, 1'b0, 2'b00, 4'd0, 8'h5A);
        bus.abort = 1'b0;
        // start_valid held: a 2-step job every 4 cycles -> 5 done pulses in 20 cycles
        @(negedge clk);
        bus.num = 8'h01; bus.d = 1'b1; bus.mode = 2'b00; bus.amt = 4'd2; bus.start_valid = 1'b1;
        dn = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done) dn++;
        end
        bus.start_valid = 1'b0;
        chk("held_dones", dn, 5);
        chk("held_y", {24'd0, bus.y}, 32'h04);
        chk("held_ready", {31'd0, bus.start_ready}, 32'd1);
        run("chg", 8'h01, 1'b1, 2'b00, 4'd3, 8'h08);
        // abort on the second SHIFT cycle
        @(negedge clk);
        bus.num = 8'h40; bus.d = 1'b0; bus.mode = 2'b00; bus.amt = 4'd5; bus.start_valid = 1'b1;
        @(negedge clk);
        bus.start_valid = 1'b0;
        @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("abort_state", {29'd0, bus.done, bus.busy, bus.start_ready}, 32'b001);
        chk("abort_y", {24'd0, bus.y}, 32'h08);
        dn = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.done) dn++;
        end
        chk("abort_nodone", dn, 0);
        // async reset in mid-SHIFT
        bus.start_valid = 1'b1;
        @(negedge clk);
        bus.start_valid = 1'b0;
        @(negedge clk);
        chk("rst_pre_busy", {31'd0, bus.busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid", {21'd0, bus.y, bus.done, bus.busy, bus.start_ready}, 32'b001);
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.done) dn++;
        end
        chk("rst_nodone", dn, 0);
        run("post_rst", 8'h01, 1'b0, 2'b10, 4'd1, 8'h80);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
